// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: NUM_IN-way operand select with a registered valid/ready output
// stage. A main register (M) feeds the output and a one-entry skid register (S)
// absorbs the beat accepted in the cycle downstream stalls. This keeps in_ready
// a pure function of registered state and still sustains one beat per cycle.
// Out-of-range selects yield zero data, a per-beat error flag and a saturating
// error count.

module mux_sel_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_cnt,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_err_q, m_err_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             s_err_q, s_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept;
  logic             drain;

  // Source select: only an exact match on a real source index drives data, so
  // unused or unknown select codes fall through to zero with the error flag set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = (state_q != StEmpty) & out_ready;

  // State and datapath registers; reset discards any held beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      m_err_q    <= 1'b0;
      s_data_q   <= '0;
      s_err_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      m_err_q    <= m_err_d;
      s_data_q   <= s_data_d;
      s_err_q    <= s_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next state: M always holds the oldest beat, S the younger one when full.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_err_d  = m_err_q;
    s_data_d = s_data_q;
    s_err_d  = s_err_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          m_data_d = sel_data;
          m_err_d  = sel_err;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          m_data_d = sel_data;
          m_err_d  = sel_err;
        end else if (accept) begin
          s_data_d = sel_data;
          s_err_d  = sel_err;
          state_d  = StTwo;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (drain) begin
          m_data_d = s_data_q;
          m_err_d  = s_err_q;
          s_data_d = '0;
          s_err_d  = 1'b0;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Registered so that in_ready never depends combinationally on out_ready.
    in_ready_d = (state_d != StTwo);
  end

  // Error counter: counted at accept time, clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && sel_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready    = in_ready_q;
    out_valid   = (state_q != StEmpty);
    out_data    = m_data_q;
    out_sel_err = m_err_q;
    err_cnt     = err_cnt_q;
  end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised successor to the 32-bit 3-to-1 forwarding mux.
- Selects one of NUM_IN WIDTH-bit sources and registers the result behind a valid/ready handshake, with a 2-entry skid buffer so throughput stays at one beat per cycle.
- Flags and counts out-of-range selects.
- Sits between operand sources (regfile, EX/MEM, MEM/WB results) and the execute stage when that stage can stall.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_IN, 3, number of sources (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- CNT_W, 8, width of the saturating select-error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary source index.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- out_data  output  WIDTH  selected, registered data.
- out_sel_err  output  1  beat at output was produced from an out-of-range select.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- err_cnt  output  CNT_W  saturating count of accepted beats with out-of-range select.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async assert, sync-safe deassert): out_data=0, out_sel_err=0, out_valid=0, in_ready=1, err_cnt=0, skid entry empty, state EMPTY.
- Select: if in_sel < NUM_IN, the selected word is source in_sel and err=0. Otherwise the selected word is all-zero and err=1. X-free: unused select codes never propagate X.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge. Output handshake completes on out_valid && out_ready.
- Latency: an accepted beat appears on out_data/out_valid the next cycle when the main register is free or is being drained that cycle.
- State machine (main reg M, skid reg S):
  - EMPTY: in_ready=1, out_valid=0. Accept -> load M -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with drain -> M reloaded, stay ONE.
    - Accept without drain -> word goes to S -> TWO.
    - Drain without accept -> EMPTY.
    - Neither -> hold.
  - TWO: out_valid=1, in_ready=0.
    - Drain -> M<=S, S cleared -> ONE.
    - Otherwise hold.
- in_ready is a registered output: it depends only on state, never combinationally on out_ready.
- Ordering: strict FIFO; beats are never dropped or duplicated. out_data/out_sel_err are stable while out_valid=1 and out_ready=0.
- Data and err flag travel together through M and S.
- err_cnt:
  - Increments by 1 on each accepted beat with err=1; saturates at 2**CNT_W-1.
  - err_clr=1 forces 0 next cycle and has priority over a simultaneous increment.
  - Counts at accept time, not drain time.
- Reset mid-operation: all held beats are discarded, state returns to EMPTY, and no out_valid pulse is generated.
- in_data/in_sel are ignored when in_valid=0.
- in_valid while in_ready=0: no effect. Upstream must hold the beat.

Test Plan:
- Sources A=0x00000000, B=0x0000000F, C=0x11F0F000; out_ready=1; in_sel = 0, 1, 2 on consecutive cycles with in_valid=1 -> out_data = 0x0, 0xF, 0x11F0F000 on the following 3 cycles; out_valid continuous; out_sel_err=0.
- in_sel=3 with NUM_IN=3, one beat -> out_data=0, out_sel_err=1, err_cnt=1; then err_clr=1 -> err_cnt=0 next cycle.
- Backpressure with out_ready=0 and 3 beats offered (sel 0,1,2):
  - First two beats accepted; in_ready=0 after the 2nd.
  - Third beat held by upstream.
  - Release out_ready -> output sequence A, B, C in order, no gaps after release.
- Random in_valid/out_ready at 50% for 1000 beats, NUM_IN=5, SEL_W=3 -> scoreboard shows an exact in-order match; err_cnt equals the number of sel>=5 beats (CNT_W=4 saturates at 15).
- Assert rst_n low while in state TWO -> out_valid=0 and in_ready=1 immediately (async); after release, the next output is only the first new beat.
- err_clr and an erroring accept in the same cycle -> err_cnt=0.
